// File: rtl/regfile_mp_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb_if
// Brief    : Bus bundle for the multi-port register file with scoreboard.
//            master = decode/writeback side, slave = register file.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_mp_sb_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NREAD*AW-1:0]     rd_addr;
  logic [NREAD*WIDTH-1:0]  rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic [NWRITE-1:0]       wr_en;
  logic [NWRITE*AW-1:0]    wr_addr;
  logic [NWRITE*WIDTH-1:0] wr_data;
  logic                    claim_en;
  logic [AW-1:0]           claim_addr;
  logic                    flush;
  logic [DEPTH-1:0]        busy_vec;
  logic [CW-1:0]           num_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
    input  rd_data, rd_busy, busy_vec, num_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
    output rd_data, rd_busy, busy_vec, num_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Brief    : Parametrised NREAD/NWRITE register file with write-through
//            bypass and a per-register busy scoreboard for hazard detection.
// Revision : 1.0  initial release
// ============================================================================
module regfile_mp_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,   // asynchronous, active low
  regfile_mp_sb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH-1:0]       r_busy;
  logic [CW-1:0]          r_num_busy;

  logic [DEPTH-1:0]       w_busy_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [NREAD*WIDTH-1:0] w_rd_data;
  logic [NREAD-1:0]       w_rd_busy;

  // Storage update: ports applied in ascending order so the highest index wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (bus.wr_en[p] &&
            !(ZERO_REG != 0 && bus.wr_addr[p*AW +: AW] == '0)) begin
          r_mem[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next scoreboard: release, then claim over it, then flush over everything
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < NWRITE; p++) begin
      if (bus.wr_en[p]) w_busy_nxt[bus.wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (bus.claim_en) w_busy_nxt[bus.claim_addr] = 1'b1;
    if (bus.flush) w_busy_nxt = '0;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  // Popcount of the next scoreboard so the count tracks busy_vec exactly
  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[r]);
    end
  end

  // Scoreboard and count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_num_busy <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_num_busy <= w_cnt_nxt;
    end
  end

  // Read ports: array read, write-through bypass, busy with same-cycle release
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [AW-1:0] ra;
      logic          hit;
      logic          claimed;
      ra      = bus.rd_addr[i*AW +: AW];
      hit     = 1'b0;
      claimed = bus.claim_en && (bus.claim_addr == ra);
      w_rd_data[i*WIDTH +: WIDTH] = r_mem[ra];
      for (int p = 0; p < NWRITE; p++) begin
        if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] == ra) begin
          w_rd_data[i*WIDTH +: WIDTH] = bus.wr_data[p*WIDTH +: WIDTH];
          hit = 1'b1;
        end
      end
      // A same-cycle claim keeps the pre-claim busy view: the claimer must
      // not stall on its own claim, and the retiring write does not release.
      w_rd_busy[i] = r_busy[ra] && !(hit && !claimed) && !bus.flush;
      if (ZERO_REG != 0 && ra == '0) begin
        w_rd_data[i*WIDTH +: WIDTH] = '0;
        w_rd_busy[i] = 1'b0;
      end
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.busy_vec = r_busy;
  assign bus.num_busy = r_num_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Brief    : Directed table-driven bench for regfile_mp_sb.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp_sb;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_mp_sb_if #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) bus ();

  regfile_mp_sb #(
    .WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ce;
    logic [4:0]  ca;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rb;
    logic [31:0] e_bv;
    logic [5:0]  e_nb;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(
    logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1,
    logic [31:0] wd1, logic ce, logic [4:0] ca, logic fl, logic [4:0] ra0,
    logic [4:0] ra1, logic [31:0] e_rd0, logic [31:0] e_rd1, logic [1:0] e_rb,
    logic [31:0] e_bv, logic [5:0] e_nb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ce = ce; v.ca = ca; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb = e_rb; v.e_bv = e_bv; v.e_nb = e_nb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.wr_en      = v.we;
    bus.wr_addr    = {v.wa1, v.wa0};
    bus.wr_data    = {v.wd1, v.wd0};
    bus.claim_en   = v.ce;
    bus.claim_addr = v.ca;
    bus.flush      = v.fl;
    bus.rd_addr    = {v.ra1, v.ra0};
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //            we    wa0 wd0           wa1 wd1           ce ca fl ra0 ra1 rd0           rd1           rb     bv            nb
    vecs[0]  = mk(2'b00, 1, 32'h0,        2, 32'h0,        0, 0, 0, 1,  2,  32'h0,        32'h0,        2'b00, 32'h0,        0);
    vecs[1]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        0);
    vecs[2]  = mk(2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0,        0);
    vecs[3]  = mk(2'b11, 7, 32'h1,        7, 32'h2,        0, 0, 0, 7,  5,  32'h2,        32'hDEADBEEF, 2'b00, 32'h0,        0);
    vecs[4]  = mk(2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 0, 7,  7,  32'h2,        32'h2,        2'b00, 32'h0,        0);
    vecs[5]  = mk(2'b10, 0, 32'h0,        0, 32'hFFFFFFFF, 1, 0, 0, 0,  7,  32'h0,        32'h2,        2'b00, 32'h0,        0);
    vecs[6]  = mk(2'b00, 0, 32'h0,        0, 32'h0,        1, 3, 0, 3,  0,  32'h0,        32'h0,        2'b00, 32'h8,        1);
    vecs[7]  = mk(2'b01, 3, 32'h9,        0, 32'h0,        1, 3, 0, 3,  3,  32'h9,        32'h9,        2'b11, 32'h8,        1);
    vecs[8]  = mk(2'b10, 0, 32'h0,        3, 32'hA,        0, 0, 0, 3,  3,  32'hA,        32'hA,        2'b00, 32'h0,        0);
    vecs[9]  = mk(2'b00, 0, 32'h0,        0, 32'h0,        1, 1, 0, 3,  0,  32'hA,        32'h0,        2'b00, 32'h2,        1);
    vecs[10] = mk(2'b00, 0, 32'h0,        0, 32'h0,        1, 2, 0, 1,  2,  32'h0,        32'h0,        2'b01, 32'h6,        2);
    vecs[11] = mk(2'b00, 0, 32'h0,        0, 32'h0,        1, 4, 0, 1,  4,  32'h0,        32'h0,        2'b01, 32'h16,       3);
    vecs[12] = mk(2'b01, 1, 32'h11,       0, 32'h0,        1, 6, 1, 1,  2,  32'h11,       32'h0,        2'b00, 32'h0,        0);
    vecs[13] = mk(2'b10, 0, 32'h0,        9, 32'h99,       0, 0, 0, 5,  9,  32'hDEADBEEF, 32'h99,       2'b00, 32'h0,        0);
    vecs[14] = mk(2'b01, 4, 32'h44,       0, 32'h0,        1, 31,0, 31, 1,  32'h0,        32'h11,       2'b00, 32'h80000000, 1);
    vecs[15] = mk(2'b00, 0, 32'h0,        0, 32'h0,        1, 31,0, 31, 4,  32'h0,        32'h44,       2'b01, 32'h80000000, 1);

    // Reset held while both write ports are active: nothing may land
    rst = 1'b0;
    drive(mk(2'b11, 1, 32'hAAAA, 2, 32'hBBBB, 1, 3, 0, 3, 4, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_vec", bus.busy_vec, 32'h0);
    chk("rst_num_busy", 32'(bus.num_busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(vecs[0]);

    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_rd0", i), bus.rd_data[31:0],  vecs[i].e_rd0);
      chk($sformatf("v%0d_rd1", i), bus.rd_data[63:32], vecs[i].e_rd1);
      chk($sformatf("v%0d_rbusy", i), 32'(bus.rd_busy), 32'(vecs[i].e_rb));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_vec", i), bus.busy_vec, vecs[i].e_bv);
      chk($sformatf("v%0d_num_busy", i), 32'(bus.num_busy), 32'(vecs[i].e_nb));
    end

    // Asynchronous reset mid-cycle with a write and a claim pending
    @(negedge clk);
    drive(mk(2'b01, 1, 32'h22, 0, 32'h0, 1, 5, 0, 7, 31, 0, 0, 0, 0, 0));
    #2 rst = 1'b0;
    #1;
    chk("async_busy_vec", bus.busy_vec, 32'h0);
    chk("async_num_busy", 32'(bus.num_busy), 32'h0);
    chk("async_rd0_r7", bus.rd_data[31:0], 32'h0);
    chk("async_rbusy", 32'(bus.rd_busy), 32'h0);
    @(posedge clk);
    #1;
    chk("inrst_busy_vec", bus.busy_vec, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(2'b00, 0, 32'h0, 0, 32'h0, 1, 2, 0, 1, 5, 0, 0, 0, 0, 0));
    #1;
    chk("post_rst_rd0_r1", bus.rd_data[31:0], 32'h0);
    chk("post_rst_rbusy", 32'(bus.rd_busy), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_busy_vec", bus.busy_vec, 32'h4);
    chk("post_rst_num_busy", 32'(bus.num_busy), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port register file for the pipelined CPU, replacing the fixed 2R/1W 32x32 file. It supports NREAD read ports, NWRITE write ports with same-cycle write-to-read bypass, and a per-register scoreboard. The scoreboard records which registers have an in-flight producer, so the hazard unit can stall on busy sources. It sits between decode (read/claim) and writeback (write/release).

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of architectural registers (power of two, >=2); localparam AW = $clog2(DEPTH)
NREAD, 2, number of combinational read ports
NWRITE, 2, number of write ports; higher port index has priority
ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
rd_addr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NREAD*WIDTH  packed read data
rd_busy  out  NREAD  scoreboard bit of each read address, after bypass
wr_en  in  NWRITE  write enables
wr_addr  in  NWRITE*AW  packed write addresses
wr_data  in  NWRITE*WIDTH  packed write data
claim_en  in  1  mark claim_addr as having an in-flight producer
claim_addr  in  AW  register being claimed
flush  in  1  clear all busy bits (pipeline squash); data untouched
busy_vec  out  DEPTH  registered scoreboard state
num_busy  out  $clog2(DEPTH+1)  registered count of set busy bits

Behaviour:
- Reset (rst=0, async): all registers = 0, busy_vec = 0, num_busy = 0. rd_data and rd_busy follow combinationally, so they are 0 for any address.
- Write: on posedge, for each port p with wr_en[p], data[wr_addr[p]] <= wr_data[p]. If several ports target the same address, the highest p wins. Writes to reg 0 are dropped when ZERO_REG=1.
- Read (combinational, zero latency): rd_data[i] = data[rd_addr[i]]. It is overridden by the highest-indexed enabled write port whose wr_addr equals rd_addr[i] (write-through bypass). rd_addr=0 with ZERO_REG=1 returns 0 even if a write targets 0.
- Busy update per register r, each posedge, in priority order:
  1. flush=1: busy[r] <= 0. Flush overrides claim and release in the same cycle.
  2. claim_en and claim_addr==r: busy[r] <= 1. A claim beats a same-cycle release of the same register, because the new producer supersedes the retiring one.
  3. any wr_en[p] with wr_addr[p]==r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- Claims and releases of reg 0 are ignored when ZERO_REG=1.
- rd_busy[i] = busy[rd_addr[i]], cleared combinationally if a same-cycle write releases it.
  - Not cleared when a same-cycle claim of that address exists: rd_busy reflects the pre-claim value, so the claiming instruction does not see its own claim.
  - Forced 0 if flush=1.
- num_busy: registered popcount of the next busy_vec, so it always equals popcount(busy_vec). Width must hold DEPTH without wrap.
- A write to a non-busy register is legal: data updates and busy stays 0.
- A claim of an already-busy register is legal: busy stays 1 and the count is unchanged.
- Out-of-range addresses cannot occur (DEPTH is a power of two).
- Reset asserted mid-operation overrides all pending writes, claims and flush. The first edge after rst deasserts behaves as normal.

Test Plan:
- Reset: hold rst=0, drive wr_en=2'b11 -> after release, every register reads 0, busy_vec=0, num_busy=0.
- Write/read with bypass: write port0 r5=32'hDEADBEEF; same cycle rd_addr[0]=5 -> rd_data[0]=DEADBEEF combinationally, and still DEADBEEF next cycle with wr_en=0.
- Write-port priority: port0 writes r7=1 and port1 writes r7=2 in the same cycle -> r7=2; same-cycle read of r7 returns 2.
- Zero register: write r0=FFFFFFFF and claim r0 -> rd_data=0, busy_vec[0]=0, num_busy unchanged.
- Scoreboard:
  - Claim r3 -> busy_vec[3]=1, num_busy=1.
  - Next cycle, claim r3 while writing r3=9 -> busy stays 1.
  - Write r3=10 with no claim -> busy clears; same-cycle rd_busy for r3 is 0 and rd_data=10.
- Flush: claim r1, r2, r4 on successive cycles (num_busy=3); then flush together with claim r6 -> busy_vec=0, num_busy=0; register data unchanged.
